// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Two-port (CPU / DMA) arbiter in front of a single-transaction SDRAM adapter.
// One transaction is in flight at a time. The CPU normally wins arbitration,
// but a waiting DMA request is guaranteed a grant after STARVE_LIMIT
// back-to-back CPU grants. Request inputs are only looked at in IDLE, so a
// requester may drop its request mid-transaction without aborting it.
module sdram_arbiter #(
   parameter int ADDR_WIDTH   = 25,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,

   input  logic                  i_cpu_req,
   input  logic                  i_cpu_rwb,
   input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
   input  logic [7:0]            i_cpu_data,
   output logic [7:0]            o_cpu_data,
   output logic                  o_cpu_done,

   input  logic                  i_dma_req,
   input  logic                  i_dma_rwb,
   input  logic [ADDR_WIDTH-1:0] i_dma_addr,
   input  logic [7:0]            i_dma_data,
   output logic [7:0]            o_dma_data,
   output logic                  o_dma_done,

   output logic                  o_sdr_req,
   output logic                  o_sdr_rwb,
   output logic [ADDR_WIDTH-1:0] o_sdr_addr,
   output logic [7:0]            o_sdr_data,
   input  logic [7:0]            i_sdr_data,
   input  logic                  i_sdr_ack,

   output logic                  o_owner
);

   // Counter wide enough to hold the value STARVE_LIMIT itself.
   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state,      state_nxt;
   logic                  owner,      owner_nxt;
   logic                  rwb,        rwb_nxt;
   logic [ADDR_WIDTH-1:0] addr,       addr_nxt;
   logic [7:0]            wdata,      wdata_nxt;
   logic [7:0]            cpu_rdata,  cpu_rdata_nxt;
   logic [7:0]            dma_rdata,  dma_rdata_nxt;
   logic [CNT_W-1:0]      starve,     starve_nxt;

   // Arbitration, transaction latching and read-data capture.
   always_comb begin
      state_nxt     = state;
      owner_nxt     = owner;
      rwb_nxt       = rwb;
      addr_nxt      = addr;
      wdata_nxt     = wdata;
      cpu_rdata_nxt = cpu_rdata;
      dma_rdata_nxt = dma_rdata;
      starve_nxt    = starve;

      case (state)
         IDLE: begin
            if (i_cpu_req || i_dma_req) begin
               state_nxt = BUSY;
               if (i_dma_req && ((starve == LIMIT) || !i_cpu_req)) begin
                  owner_nxt  = 1'b1;
                  rwb_nxt    = i_dma_rwb;
                  addr_nxt   = i_dma_addr;
                  wdata_nxt  = i_dma_data;
                  starve_nxt = '0;
               end else begin
                  owner_nxt = 1'b0;
                  rwb_nxt   = i_cpu_rwb;
                  addr_nxt  = i_cpu_addr;
                  wdata_nxt = i_cpu_data;
                  if (!i_dma_req) begin
                     starve_nxt = '0;
                  end else if (starve != LIMIT) begin
                     starve_nxt = starve + CNT_W'(1);
                  end
               end
            end
         end
         BUSY: begin
            if (i_sdr_ack) begin
               state_nxt = DONE;
               if (rwb) begin
                  if (owner) begin
                     dma_rdata_nxt = i_sdr_data;
                  end else begin
                     cpu_rdata_nxt = i_sdr_data;
                  end
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         owner     <= 1'b0;
         rwb       <= 1'b0;
         addr      <= '0;
         wdata     <= '0;
         cpu_rdata <= '0;
         dma_rdata <= '0;
         starve    <= '0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         rwb       <= rwb_nxt;
         addr      <= addr_nxt;
         wdata     <= wdata_nxt;
         cpu_rdata <= cpu_rdata_nxt;
         dma_rdata <= dma_rdata_nxt;
         starve    <= starve_nxt;
      end
   end

   assign o_sdr_req  = (state == BUSY);
   assign o_sdr_rwb  = rwb;
   assign o_sdr_addr = addr;
   assign o_sdr_data = wdata;
   assign o_owner    = owner;
   assign o_cpu_data = cpu_rdata;
   assign o_dma_data = dma_rdata;
   assign o_cpu_done = (state == DONE) && !owner;
   assign o_dma_done = (state == DONE) &&  owner;

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 25, the byte address width of every port.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, the maximum number of consecutive CPU grants while a DMA request waits.
REQ-003 SHALL have port i_clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have port i_cpu_req  in  1  CPU level request.
REQ-006 SHALL have port i_cpu_rwb  in  1  CPU direction: 1 = read, 0 = write.
REQ-007 SHALL have port i_cpu_addr  in  ADDR_WIDTH  CPU address.
REQ-008 SHALL have port i_cpu_data  in  8  CPU write data.
REQ-009 SHALL have port o_cpu_data  out  8  CPU read data.
REQ-010 SHALL have port o_cpu_done  out  1  one-cycle completion pulse for the CPU.
REQ-011 SHALL have ports i_dma_req, i_dma_rwb, i_dma_addr, i_dma_data, o_dma_data and o_dma_done, identical in direction, width and meaning to REQ-005..010, for the DMA requester.
REQ-012 SHALL have port o_sdr_req  out  1  request to the SDRAM adapter.
REQ-013 SHALL have port o_sdr_rwb  out  1  direction of the granted transaction.
REQ-014 SHALL have port o_sdr_addr  out  ADDR_WIDTH  address of the granted transaction.
REQ-015 SHALL have port o_sdr_data  out  8  write data of the granted transaction.
REQ-016 SHALL have port i_sdr_data  in  8  SDRAM read data, valid while i_sdr_ack is high.
REQ-017 SHALL have port i_sdr_ack  in  1  one-cycle completion from the adapter.
REQ-018 SHALL have port o_owner  out  1  current grant holder: 0 = CPU, 1 = DMA.

Function
REQ-019 SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-020 In IDLE with either request high, SHALL select a winner, latch its rwb, addr and data into output registers, set o_owner, and enter BUSY on the same edge.
REQ-021 SHALL give the CPU the win unless i_dma_req is high and the starve counter equals STARVE_LIMIT, in which case the DMA wins.
REQ-022 Starve counter: increments, saturating at STARVE_LIMIT, on each CPU grant while i_dma_req is high; clears to 0 on a DMA grant; clears to 0 on any grant made while i_dma_req is low.
REQ-023 SHALL drive o_sdr_req = 1 exactly while in BUSY, holding o_sdr_rwb, o_sdr_addr and o_sdr_data stable.
REQ-024 In BUSY, when i_sdr_ack = 1: if rwb = 1, SHALL capture i_sdr_data into the owner's read-data register; in all cases SHALL enter DONE.
REQ-025 In DONE, SHALL pulse the owner's done output high for exactly one cycle and return to IDLE.
REQ-026 Latency: a request seen at edge N gives o_sdr_req high from cycle N+1; an ack seen at edge M gives done high in cycle M+1.
REQ-027 A requester that still holds req in its done cycle SHALL be treated as a new request at the next IDLE arbitration.
REQ-028 Request inputs SHALL be sampled only at grant; deasserting req during BUSY SHALL NOT abort the transaction, and done SHALL still pulse.
REQ-029 SHALL ignore i_sdr_ack in IDLE and DONE.
REQ-030 A read-data register SHALL change only on a completed read for that port; writes SHALL leave it unchanged.
REQ-031 SHALL never assert o_cpu_done and o_dma_done in the same cycle.

Reset
REQ-032 With i_rst_n = 0 at an edge, SHALL set: state IDLE, all outputs 0, o_owner 0, starve counter 0, both read-data registers 0x00.
REQ-033 Reset during BUSY SHALL abandon the transaction: o_sdr_req is 0 after that edge and no done pulse follows.

Verification
REQ-034 CPU read of 0x0001234, ack with 0xA5 three cycles after o_sdr_req rises -> o_sdr_req high for 3 cycles, o_cpu_data = 0xA5, a single o_cpu_done pulse one cycle after the ack, o_dma_done stays 0.
REQ-035 Both requests rise on the same edge, adapter acks immediately -> the CPU is served first (o_owner = 0), then the DMA (o_owner = 1).
REQ-036 Both requests held high continuously, STARVE_LIMIT = 4 -> grant order C,C,C,C,D,C,C,C,C,D.
REQ-037 DMA write of 0x3C to 0x1FFFFFF -> o_sdr_rwb = 0, o_sdr_addr = 0x1FFFFFF, o_sdr_data = 0x3C; o_dma_data keeps its previous value.
REQ-038 i_rst_n pulsed low for one cycle during BUSY, then an ack -> o_sdr_req is 0 after the reset edge, no done pulse on either port, state IDLE.
REQ-039 i_sdr_ack pulsed while in IDLE with no requests -> no done pulse, both read-data registers unchanged.
